// File: rtl/ac_xor_arbiter.sv
// ----------------------------------------------------------------------------
// ac_xor_arbiter
//
// Purpose:
//   Shares a single gate-level XOR unit among NUM_REQ requesters. In IDLE a
//   round-robin search picks one requester and shows it on req_ready. When
//   the request is accepted, the winner's operands are registered onto
//   xor_a/xor_b. The block then waits SETTLE_CYCLES clocks for the slow XOR
//   unit to settle, captures xor_c into rsp_data, and pulses rsp_valid for
//   one cycle to the requester that owns the operation.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NUM_REQ]        per-requester request
//   req_ready  out  [NUM_REQ]        one-hot grant (combinational, IDLE only)
//   req_a      in   [NUM_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NUM_REQ*WIDTH]  operand B, same packing
//   xor_a      out  [WIDTH]          registered operand A to the XOR unit
//   xor_b      out  [WIDTH]          registered operand B to the XOR unit
//   xor_c      in   [WIDTH]          result from the XOR unit
//   rsp_valid  out  [NUM_REQ]        one-hot, one-cycle response pulse
//   rsp_data   out  [WIDTH]          captured result, held between responses
//   busy       out                   high whenever the FSM is not in IDLE
//   rsp_err    out                   (only with AC_XOR_ARB_CHECK_EN) high when
//                                    the captured result disagrees with a
//                                    behavioural XOR of the driven operands
//
// Build option:
//   AC_XOR_ARB_CHECK_EN - when defined, adds the rsp_err port and its check.
// ----------------------------------------------------------------------------
module ac_xor_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         xor_a,
  output logic [WIDTH-1:0]         xor_b,
  input  logic [WIDTH-1:0]         xor_c,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy
`ifdef AC_XOR_ARB_CHECK_EN
  ,
  output logic                     rsp_err
`endif
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("ac_xor_arbiter: SETTLE_CYCLES must be >= 1");
    end
    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
      $error("ac_xor_arbiter: NUM_REQ must be in 2..8");
    end
  endgenerate

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_next;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_xor_a;
  logic [WIDTH-1:0]   r_xor_b;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [PTR_W:0]       w_start;
  logic                 w_found;
  logic [PTR_W-1:0]     w_win_idx;
  logic [NUM_REQ-1:0]   w_grant;
  logic [WIDTH-1:0]     w_sel_a;
  logic [WIDTH-1:0]     w_sel_b;
  logic                 w_accept;
  logic                 w_capture;

`ifdef AC_XOR_ARB_CHECK_EN
  logic               r_rsp_err;
  logic [WIDTH-1:0]   w_ref_xor;
`endif

  // --------------------------------------------------------------------------
  // Round-robin search
  // --------------------------------------------------------------------------
  // Rotating the doubled request vector by pointer+1 puts the highest-priority
  // requester at bit 0; the lowest set bit of the rotated vector is the winner.
  // The extra start bit keeps pointer+1 from wrapping in PTR_W bits.
  assign w_start   = {1'b0, r_ptr} + {{PTR_W{1'b0}}, 1'b1};
  assign w_req_dbl = {req_valid, req_valid};

  // Rotate requests so the search always starts at bit 0.
  always_comb begin
    w_req_rot = w_req_dbl[NUM_REQ-1:0];
    w_req_rot = NUM_REQ'(w_req_dbl >> w_start);
  end

  // Lowest set bit of the rotated vector; descending loop so the smallest
  // offset is assigned last and wins.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = {PTR_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_found   = w_found | w_req_rot[k];
      w_win_idx = w_req_rot[k] ? PTR_W'((int'(r_ptr) + 1 + k) % NUM_REQ) : w_win_idx;
    end
  end

  assign w_grant = w_found ? f_onehot(w_win_idx) : {NUM_REQ{1'b0}};

  // Operand mux for the winning requester.
  always_comb begin
    w_sel_a = {WIDTH{1'b0}};
    w_sel_b = {WIDTH{1'b0}};
    for (int r = 0; r < NUM_REQ; r++) begin
      w_sel_a = (w_win_idx == PTR_W'(r)) ? req_a[r*WIDTH +: WIDTH] : w_sel_a;
      w_sel_b = (w_win_idx == PTR_W'(r)) ? req_b[r*WIDTH +: WIDTH] : w_sel_b;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and grant decode.
  always_comb begin
    w_next    = r_state;
    req_ready = {NUM_REQ{1'b0}};
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = w_grant;
        w_accept  = w_found;
        w_next    = w_found ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        w_capture = (r_cnt == {CNT_W{1'b0}});
        w_next    = w_capture ? S_RESP : S_SETTLE;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Operand drive, ownership, pointer and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xor_a <= {WIDTH{1'b0}};
      r_xor_b <= {WIDTH{1'b0}};
      r_owner <= {PTR_W{1'b0}};
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_xor_a <= w_sel_a;
      r_xor_b <= w_sel_b;
      r_owner <= w_win_idx;
      r_ptr   <= w_win_idx;
      r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((r_state == S_SETTLE) && !w_capture) begin
      r_cnt   <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt   <= r_cnt;
    end
  end

  // Result capture and one-cycle response pulse (high during RESP).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data  <= {WIDTH{1'b0}};
      r_rsp_valid <= {NUM_REQ{1'b0}};
    end else if (w_capture) begin
      r_rsp_data  <= xor_c;
      r_rsp_valid <= f_onehot(r_owner);
    end else begin
      r_rsp_valid <= {NUM_REQ{1'b0}};
    end
  end

`ifdef AC_XOR_ARB_CHECK_EN
  assign w_ref_xor = r_xor_a ^ r_xor_b;

  // Flag a result that differs from the ideal XOR: settle time too short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_err <= 1'b0;
    end else if (w_capture) begin
      r_rsp_err <= (xor_c != w_ref_xor);
    end else begin
      r_rsp_err <= r_rsp_err;
    end
  end

  assign rsp_err = r_rsp_err;
`endif

  assign xor_a     = r_xor_a;
  assign xor_b     = r_xor_b;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = r_rsp_valid;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ac_xor_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ac_xor_arbiter
//
// Directed bench for ac_xor_arbiter (NUM_REQ=4, WIDTH=8, SETTLE_CYCLES=2).
// The shared XOR unit is modelled here; with AC_XOR_ARB_CHECK_EN defined it
// can be switched into a slow mode that lags the operands by three clocks.
// ----------------------------------------------------------------------------
module tb_ac_xor_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  xor_a;
  logic [7:0]  xor_b;
  logic [7:0]  xor_c;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  logic [7:0]  a_tab [4];
  logic [7:0]  b_tab [4];
  logic [7:0]  e_tab [4];

  int n_chk;
  int n_pass;

  assign req_a = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
  assign req_b = {b_tab[3], b_tab[2], b_tab[1], b_tab[0]};

`ifdef AC_XOR_ARB_CHECK_EN
  logic       rsp_err;
  logic       slow;
  logic [7:0] dly [3];

  // Delay line used to model an XOR unit slower than the settle window.
  always_ff @(posedge clk) begin
    dly[0] <= xor_a ^ xor_b;
    dly[1] <= dly[0];
    dly[2] <= dly[1];
  end

  assign xor_c = slow ? dly[2] : (xor_a ^ xor_b);
`else
  assign xor_c = xor_a ^ xor_b;
`endif

  ac_xor_arbiter #(
    .NUM_REQ      (4),
    .WIDTH        (8),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .xor_a    (xor_a),
    .xor_b    (xor_b),
    .xor_c    (xor_c),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy)
`ifdef AC_XOR_ARB_CHECK_EN
    ,
    .rsp_err  (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expect requester g to win in the current IDLE cycle and follow the whole
  // operation through to the cycle after its response.
  task automatic serve(input int g, input string tag);
    #1;
    chk({tag, "_ready"}, {28'd0, req_ready}, 32'd1 << g);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    cyc();  // T+1
    chk({tag, "_xor_a"}, {24'd0, xor_a}, {24'd0, a_tab[g]});
    chk({tag, "_xor_b"}, {24'd0, xor_b}, {24'd0, b_tab[g]});
    chk({tag, "_settle_ready"}, {28'd0, req_ready}, 32'd0);
    chk({tag, "_settle_busy"}, {31'd0, busy}, 32'd1);
    cyc();  // T+2
    chk({tag, "_early_rsp"}, {28'd0, rsp_valid}, 32'd0);
    cyc();  // T+3
    chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd1 << g);
    chk({tag, "_rsp_data"}, {24'd0, rsp_data}, {24'd0, e_tab[g]});
    cyc();  // T+4
    chk({tag, "_rsp_drop"}, {28'd0, rsp_valid}, 32'd0);
    chk({tag, "_data_hold"}, {24'd0, rsp_data}, {24'd0, e_tab[g]});
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    a_tab[0] = 8'hA5; b_tab[0] = 8'h0F; e_tab[0] = 8'hAA;
    a_tab[1] = 8'h3C; b_tab[1] = 8'hC3; e_tab[1] = 8'hFF;
    a_tab[2] = 8'h5A; b_tab[2] = 8'h0F; e_tab[2] = 8'h55;
    a_tab[3] = 8'h80; b_tab[3] = 8'h01; e_tab[3] = 8'h81;
`ifdef AC_XOR_ARB_CHECK_EN
    slow = 1'b0;
`endif

    // Reset then idle.
    rst       = 1'b1;
    req_valid = 4'b0000;
    cyc();
    cyc();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_xor_a", {24'd0, xor_a}, 32'd0);
    chk("rst_xor_b", {24'd0, xor_b}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ready", {28'd0, req_ready}, 32'd0);

    // Single op on requester 0: A5 ^ 0F = AA.
    req_valid = 4'b0001;
    serve(0, "single");
    req_valid = 4'b0000;
    cyc();

    // Reset in IDLE returns the pointer so requester 0 wins first.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // Round robin with all requesters continuously valid: 0,1,2,3,0.
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(k % 4, "rr");
    end

    // Wrap/priority: serve 2, then 0101 searches 3,0 and picks 0.
    req_valid = 4'b0100;
    serve(2, "wrap_pre");
    req_valid = 4'b0101;
    serve(0, "wrap_0");
    serve(2, "wrap_2");

    // Mid-op reset: accept requester 1, reset during SETTLE.
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", {28'd0, req_ready}, 32'd2);
    cyc();
    req_valid = 4'b0000;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_xor_a", {24'd0, xor_a}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("mid_no_rsp", {28'd0, rsp_valid}, 32'd0);
    end
    rst = 1'b0;
    cyc();
    chk("post_rst_no_rsp", {28'd0, rsp_valid}, 32'd0);
    req_valid = 4'b0011;
    serve(0, "post_rst_0");
    serve(1, "post_rst_1");
    req_valid = 4'b0000;
    cyc();

`ifdef AC_XOR_ARB_CHECK_EN
    // Correct XOR unit: no error.
    a_tab[3] = 8'hFF; b_tab[3] = 8'h00; e_tab[3] = 8'hFF;
    req_valid = 4'b1000;
    serve(3, "chk_fast");
    chk("chk_fast_err", {31'd0, rsp_err}, 32'd0);
    a_tab[3] = 8'h12; b_tab[3] = 8'h34; e_tab[3] = 8'h26;
    serve(3, "chk_fast2");
    chk("chk_fast2_err", {31'd0, rsp_err}, 32'd0);
    // Slow XOR unit: the previous result 26 is still on xor_c at capture.
    slow = 1'b1;
    a_tab[3] = 8'hFF; b_tab[3] = 8'h00; e_tab[3] = 8'h26;
    serve(3, "chk_slow");
    chk("chk_slow_err", {31'd0, rsp_err}, 32'd1);
    req_valid = 4'b0000;
    slow = 1'b0;
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
